// File: rtl/duc_hop_sched_pkg.sv
// duc_hop_sched_pkg: shared widths, reset FCW and FSM encoding for the hop scheduler
package duc_hop_sched_pkg;
  localparam int FCW_W   = 28;
  localparam int DEPTH   = 16;
  localparam int IDX_W   = 4;
  localparam int DWELL_W = 16;
  localparam int GUARD_W = 8;
  localparam logic [FCW_W-1:0] DEFAULT_FCW = 28'h5333333;
  typedef enum logic [1:0] {IDLE = 2'd0, GUARD = 2'd1, DWELL = 2'd2} state_t;
  function automatic logic [IDX_W-1:0] last_idx(input logic [IDX_W:0] n);
    logic [IDX_W:0] m;
    m = (n > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : n;
    m = m - (IDX_W+1)'(1);
    return m[IDX_W-1:0];
  endfunction
endpackage

// File: rtl/duc_fcw_table.sv
// duc_fcw_table: hop-table register file, sync write, async read, reset to DEFAULT_FCW
module duc_fcw_table
  import duc_hop_sched_pkg::*;
(
  input  logic             clk_200m,
  input  logic             cfg_rst_n,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_addr,
  input  logic [FCW_W-1:0] i_wr_fcw,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [FCW_W-1:0] o_rd_fcw
);
  logic [FCW_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk_200m) begin
    if (!cfg_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= DEFAULT_FCW;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_fcw;
    end
  end
  assign o_rd_fcw = r_mem[i_rd_addr];
endmodule

// File: rtl/duc_hop_sched.sv
// duc_hop_sched: steps the DUC DDS through the hop table with guard/dwell timing
module duc_hop_sched
  import duc_hop_sched_pkg::*;
(
  input  logic               clk_200m,
  input  logic               cfg_rst_n,
  input  logic               cfg_wr_en,
  input  logic [IDX_W-1:0]   cfg_wr_addr,
  input  logic [FCW_W-1:0]   cfg_wr_fcw,
  input  logic [IDX_W:0]     cfg_num_hops,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [GUARD_W-1:0] cfg_guard,
  input  logic               cfg_loop,
  input  logic               hop_start,
  input  logic               hop_stop,
  output logic [FCW_W-1:0]   fcw_data,
  output logic               tx_dds_en,
  output logic [IDX_W-1:0]   hop_idx,
  output logic               hop_strobe,
  output logic               busy,
  output logic               done
);
  state_t             r_state, w_state_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt, r_last;
  logic [DWELL_W-1:0] r_dwell, w_d_eff;
  logic [GUARD_W-1:0] r_guard, w_g_eff;
  logic               r_loop;
  logic [FCW_W-1:0]   r_fcw, w_rd_fcw;
  logic               r_en, w_en_nxt, r_strobe, w_strobe_nxt, r_busy, r_done, w_done_nxt;
  logic               w_load, w_last_hop;
  assign w_load     = (r_state == IDLE) && hop_start && (cfg_num_hops != '0) && !hop_stop;
  assign w_g_eff    = (cfg_guard == '0) ? GUARD_W'(1) : cfg_guard;
  assign w_d_eff    = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
  assign w_last_hop = (r_idx == r_last);
  duc_fcw_table u_tab (
    .clk_200m  (clk_200m),
    .cfg_rst_n (cfg_rst_n),
    .i_wr_en   (cfg_wr_en),
    .i_wr_addr (cfg_wr_addr),
    .i_wr_fcw  (cfg_wr_fcw),
    .i_rd_addr (w_idx_nxt),
    .o_rd_fcw  (w_rd_fcw)
  );
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_en_nxt     = r_en;
    w_strobe_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    if (hop_stop) begin
      w_state_nxt = IDLE;
      w_en_nxt    = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_load) begin
          w_state_nxt  = GUARD;
          w_idx_nxt    = '0;
          w_cnt_nxt    = DWELL_W'(w_g_eff);
          w_strobe_nxt = 1'b1;
          w_en_nxt     = 1'b0;
        end
        GUARD: if (r_cnt == DWELL_W'(1)) begin
          w_state_nxt = DWELL;
          w_cnt_nxt   = r_dwell;
          w_en_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end
        DWELL: if (r_cnt != DWELL_W'(1)) begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end else if (!w_last_hop || r_loop) begin
          w_state_nxt  = GUARD;
          w_idx_nxt    = w_last_hop ? '0 : r_idx + IDX_W'(1);
          w_cnt_nxt    = DWELL_W'(r_guard);
          w_strobe_nxt = 1'b1;
          w_en_nxt     = 1'b0;
        end else begin
          w_state_nxt = IDLE;
          w_en_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_en_nxt    = 1'b0;
        end
      endcase
    end
  end
  // Table is read at the index about to be latched, so a same-cycle write yields the old entry.
  always_ff @(posedge clk_200m) begin
    if (!cfg_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_last   <= '0;
      r_dwell  <= DWELL_W'(1);
      r_guard  <= GUARD_W'(1);
      r_loop   <= 1'b0;
      r_fcw    <= DEFAULT_FCW;
      r_en     <= 1'b0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_fcw    <= w_strobe_nxt ? w_rd_fcw : r_fcw;
      r_en     <= w_en_nxt;
      r_strobe <= w_strobe_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= w_done_nxt;
      if (w_load) begin
        r_last  <= last_idx(cfg_num_hops);
        r_dwell <= w_d_eff;
        r_guard <= w_g_eff;
        r_loop  <= cfg_loop;
      end
    end
  end
  assign fcw_data   = r_fcw;
  assign tx_dds_en  = r_en;
  assign hop_idx    = r_idx;
  assign hop_strobe = r_strobe;
  assign busy       = r_busy;
  assign done       = r_done;
endmodule

// File: tb/tb_duc_hop_sched.sv
// tb_duc_hop_sched: schedule-arithmetic model checked every cycle plus directed literal checks
module tb_duc_hop_sched;
  logic        clk_200m = 1'b0;
  logic        cfg_rst_n = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [3:0]  cfg_wr_addr = '0;
  logic [27:0] cfg_wr_fcw = '0;
  logic [4:0]  cfg_num_hops = '0;
  logic [15:0] cfg_dwell = '0;
  logic [7:0]  cfg_guard = '0;
  logic        cfg_loop = 1'b0;
  logic        hop_start = 1'b0;
  logic        hop_stop = 1'b0;
  logic [27:0] fcw_data;
  logic        tx_dds_en;
  logic [3:0]  hop_idx;
  logic        hop_strobe, busy, done;
  int total = 0;
  int bad = 0;

  always #5 clk_200m = ~clk_200m;

  duc_hop_sched dut (
    .clk_200m(clk_200m), .cfg_rst_n(cfg_rst_n), .cfg_wr_en(cfg_wr_en),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_fcw(cfg_wr_fcw), .cfg_num_hops(cfg_num_hops),
    .cfg_dwell(cfg_dwell), .cfg_guard(cfg_guard), .cfg_loop(cfg_loop),
    .hop_start(hop_start), .hop_stop(hop_stop), .fcw_data(fcw_data),
    .tx_dds_en(tx_dds_en), .hop_idx(hop_idx), .hop_strobe(hop_strobe),
    .busy(busy), .done(done)
  );

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Model: outputs derived from elapsed cycles k since the first GUARD entry.
  logic [27:0] m_tab [16];
  logic [27:0] e_fcw;
  logic [3:0]  e_idx;
  logic        e_en, e_strobe, e_busy, e_done;
  bit          m_valid = 0, m_act = 0, m_loop = 0;
  int          k = 0, m_n = 1, m_g = 1, m_d = 1;

  always @(posedge clk_200m) begin
    if (!cfg_rst_n) begin
      for (int i = 0; i < 16; i++) m_tab[i] = 28'h5333333;
      e_fcw = 28'h5333333; e_idx = 0; e_en = 0; e_strobe = 0; e_busy = 0; e_done = 0;
      m_act = 0; m_valid = 1;
    end else begin
      e_strobe = 0; e_done = 0;
      if (hop_stop) begin
        m_act = 0; e_busy = 0; e_en = 0;
      end else if (m_act) begin
        k++;
      end else if (hop_start && cfg_num_hops != 0) begin
        m_act = 1; k = 0;
        m_n = (cfg_num_hops > 16) ? 16 : int'(cfg_num_hops);
        m_g = (cfg_guard == 0) ? 1 : int'(cfg_guard);
        m_d = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        m_loop = cfg_loop;
      end
      if (m_act) begin
        int hop, ph;
        hop = k / (m_g + m_d);
        ph  = k % (m_g + m_d);
        if (!m_loop && hop >= m_n) begin
          m_act = 0; e_done = 1; e_busy = 0; e_en = 0;
        end else begin
          e_busy = 1;
          e_en = (ph >= m_g);
          if (ph == 0) begin
            e_strobe = 1;
            e_idx = 4'(hop % m_n);
            e_fcw = m_tab[hop % m_n];
          end
        end
      end
      if (cfg_wr_en) m_tab[cfg_wr_addr] = cfg_wr_fcw;
    end
  end

  always @(negedge clk_200m) begin
    if (m_valid) begin
      cmp("fcw", 32'(fcw_data), 32'(e_fcw));
      cmp("en", 32'(tx_dds_en), 32'(e_en));
      cmp("idx", 32'(hop_idx), 32'(e_idx));
      cmp("strobe", 32'(hop_strobe), 32'(e_strobe));
      cmp("busy", 32'(busy), 32'(e_busy));
      cmp("done", 32'(done), 32'(e_done));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_200m);
  endtask
  task automatic wr(input logic [3:0] a, input logic [27:0] d);
    cfg_wr_en = 1; cfg_wr_addr = a; cfg_wr_fcw = d;
    tick(1);
    cfg_wr_en = 0;
  endtask
  task automatic start();
    hop_start = 1;
    tick(1);
    hop_start = 0;
  endtask
  task automatic stop();
    hop_stop = 1;
    tick(1);
    hop_stop = 0;
  endtask
  task automatic cfg(input logic [4:0] n, input logic [7:0] g, input logic [15:0] d, input logic l);
    cfg_num_hops = n; cfg_guard = g; cfg_dwell = d; cfg_loop = l;
  endtask
  task automatic wait_idle(input int lim);
    int c = 0;
    while (busy && c < lim) begin
      tick(1);
      c++;
    end
    cmp("idle_timeout", 32'(busy), 32'd0);
    tick(2);
  endtask

  initial begin
    tick(3);
    cmp("rst_fcw", 32'(fcw_data), 32'h5333333);
    cmp("rst_en", 32'(tx_dds_en), 0);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_done", 32'(done), 0);
    cfg_rst_n = 1;
    tick(1);
    wr(0, 28'h1000000); wr(1, 28'h2000000); wr(2, 28'h3000000);
    cfg(3, 4, 10, 0);
    start();
    cmp("sp_fcw1", 32'(fcw_data), 32'h1000000);
    cmp("sp_stb1", 32'(hop_strobe), 1);
    tick(3);  cmp("sp_en4", 32'(tx_dds_en), 0);
    tick(1);  cmp("sp_en5", 32'(tx_dds_en), 1);
    tick(9);  cmp("sp_en14", 32'(tx_dds_en), 1);
    tick(1);  cmp("sp_fcw15", 32'(fcw_data), 32'h2000000);
              cmp("sp_en15", 32'(tx_dds_en), 0);
    tick(14); cmp("sp_fcw29", 32'(fcw_data), 32'h3000000);
              cmp("sp_stb29", 32'(hop_strobe), 1);
    tick(13); cmp("sp_en42", 32'(tx_dds_en), 1);
    tick(1);  cmp("sp_done43", 32'(done), 1);
              cmp("sp_busy43", 32'(busy), 0);
    tick(1);  cmp("sp_done44", 32'(done), 0);
    cfg(2, 0, 0, 1);
    start();
    cmp("lp_idx1", 32'(hop_idx), 0); cmp("lp_en1", 32'(tx_dds_en), 0);
    tick(1); cmp("lp_en2", 32'(tx_dds_en), 1);
    tick(1); cmp("lp_idx3", 32'(hop_idx), 1); cmp("lp_fcw3", 32'(fcw_data), 32'h2000000);
    tick(1); cmp("lp_en4", 32'(tx_dds_en), 1);
    tick(1); cmp("lp_idx5", 32'(hop_idx), 0); cmp("lp_fcw5", 32'(fcw_data), 32'h1000000);
    stop();
    cmp("lp_stop_busy", 32'(busy), 0); cmp("lp_stop_done", 32'(done), 0);
    cmp("lp_stop_fcw", 32'(fcw_data), 32'h1000000);
    tick(2);
    cfg(3, 2, 5, 0);
    start();
    tick(10);
    cmp("ab_en11", 32'(tx_dds_en), 1); cmp("ab_idx11", 32'(hop_idx), 1);
    stop();
    cmp("ab_en12", 32'(tx_dds_en), 0); cmp("ab_fcw12", 32'(fcw_data), 32'h2000000);
    cmp("ab_busy12", 32'(busy), 0);
    tick(3);
    start();
    cmp("ab_restart_fcw", 32'(fcw_data), 32'h1000000); cmp("ab_restart_idx", 32'(hop_idx), 0);
    stop();
    tick(1);
    cfg(0, 2, 5, 0);
    start();
    cmp("n0_busy", 32'(busy), 0); cmp("n0_stb", 32'(hop_strobe), 0);
    tick(1);
    cfg(20, 0, 0, 0);
    start();
    tick(30);
    cmp("n20_idx31", 32'(hop_idx), 15); cmp("n20_fcw31", 32'(fcw_data), 32'h5333333);
    tick(2);
    cmp("n20_done33", 32'(done), 1);
    tick(1);
    cfg(3, 2, 5, 0);
    hop_start = 1; hop_stop = 1;
    tick(1);
    hop_start = 0; hop_stop = 0;
    cmp("ss_busy", 32'(busy), 0); cmp("ss_stb", 32'(hop_strobe), 0);
    tick(1);
    cfg(3, 2, 4, 0);
    start();
    cfg_dwell = 3;
    wr(1, 28'hABCDEF0);
    tick(5);
    cmp("lv_fcw7", 32'(fcw_data), 32'hABCDEF0); cmp("lv_stb7", 32'(hop_strobe), 1);
    tick(5);
    cmp("lv_en12", 32'(tx_dds_en), 1);
    wr(2, 28'h7777777);
    cmp("lv_old13", 32'(fcw_data), 32'h3000000); cmp("lv_stb13", 32'(hop_strobe), 1);
    wait_idle(40);
    start();
    tick(10);
    cmp("lv_new11", 32'(fcw_data), 32'h7777777);
    wait_idle(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/duc_hop_sched.md
Name: duc_hop_sched

Overview:
Frequency-hop scheduler that configures and sequences the digital up-converter's DDS.
- Holds a 16-entry table of 28-bit frequency control words (FCWs).
- On command, steps the DUC through the table. Each hop is a guard interval (DDS disabled while retuning) followed by a dwell interval (DDS enabled).
- Drives the DUC's fcw_data and tx_dds_en inputs directly, replacing the fixed-FCW register in the DUC wrapper.

Parameters:
FCW_W, 28, FCW width
DEPTH, 16, number of hop-table entries
IDX_W, 4, table index width
DWELL_W, 16, dwell counter width
GUARD_W, 8, guard counter width
DEFAULT_FCW, 28'h5333333, FCW after reset and table reset value

Ports:
clk_200m  in  1  system clock; the only clock
cfg_rst_n  in  1  reset, synchronous, active-low
cfg_wr_en  in  1  table write strobe
cfg_wr_addr  in  IDX_W  table write address
cfg_wr_fcw  in  FCW_W  table write data
cfg_num_hops  in  IDX_W+1  hops per sequence, 1..16; values >16 clamp to 16
cfg_dwell  in  DWELL_W  DDS-on cycles per hop
cfg_guard  in  GUARD_W  DDS-off retune cycles per hop
cfg_loop  in  1  1 = wrap to entry 0 after the last hop
hop_start  in  1  one-cycle start pulse
hop_stop  in  1  one-cycle abort pulse
fcw_data  out  FCW_W  FCW to DUC
tx_dds_en  out  1  DDS enable to DUC
hop_idx  out  IDX_W  index of the active entry
hop_strobe  out  1  one-cycle pulse when a new FCW is applied
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at normal sequence end

Behaviour:
- Reset values: clk_200m is the only clock; cfg_rst_n is synchronous and active-low. When cfg_rst_n=0 at a clock edge:
  - fcw_data=DEFAULT_FCW; tx_dds_en=0; hop_idx=0; hop_strobe=0; busy=0; done=0.
  - State=IDLE; all table entries=DEFAULT_FCW.
- Table: synchronous write on cfg_wr_en, accepted in any state. Reads are combinational. A write to the entry being latched in the same cycle supplies the old value; the new value is used on the next visit.
- All outputs are registered.
- States: IDLE, GUARD, DWELL.
- IDLE:
  - tx_dds_en=0; fcw_data holds its last value.
  - On hop_start with cfg_num_hops!=0, shadow-latch num_hops (clamped), dwell, guard and loop; set idx=0; go to GUARD.
  - hop_start with cfg_num_hops=0 is ignored.
- GUARD entry cycle: fcw_data<=table[idx], hop_idx<=idx, hop_strobe=1. GUARD lasts max(1, guard) cycles with tx_dds_en=0, then goes to DWELL.
- DWELL: tx_dds_en=1 for max(1, dwell) cycles. At the end:
  - idx<num_hops-1: idx+1, go to GUARD.
  - Last entry and loop=1: idx=0, go to GUARD.
  - Last entry and loop=0: go to IDLE, tx_dds_en=0, done=1 for one cycle.
- Latency: hop_start at cycle T gives GUARD, hop_strobe and the new FCW at T+1. tx_dds_en rises at T+1+G and falls at T+1+G+D. Hop period = G+D cycles (G,D = effective guard/dwell).
- Shadow registers: changes to cfg_dwell, cfg_guard, cfg_num_hops or cfg_loop while busy have no effect until the next hop_start.
- hop_stop: priority over everything except reset. From any state, next cycle gives IDLE, tx_dds_en=0, no done pulse; fcw_data holds its value.
- Simultaneous events:
  - hop_start together with hop_stop in IDLE: stays IDLE.
  - hop_start while busy: ignored.
- Counters: count down from the loaded value to 1; no wrap at maximum values (dwell=65535 is valid).

Decomposition:
- Shared duc package/include holds: FCW_W, DEFAULT_FCW, state encodings (IDLE=2'd0, GUARD=2'd1, DWELL=2'd2).
- One sub-module: duc_fcw_table, a DEPTHxFCW_W register file with sync write, async read and sync reset to DEFAULT_FCW.
- duc_hop_sched holds the FSM, counters and shadow registers.

Test Plan:
- Reset: hold cfg_rst_n=0 for 3 cycles -> fcw_data=28'h5333333, tx_dds_en=0, busy=0, done=0.
- Single pass: write entries 0..2 = 28'h1000000, 28'h2000000, 28'h3000000; num_hops=3, guard=4, dwell=10, loop=0; hop_start at T ->
  - fcw_data changes at T+1, T+15, T+29 with hop_strobe at each.
  - tx_dds_en high T+5..T+14, T+19..T+28, T+33..T+42.
  - done at T+43; busy low from T+43.
- Loop: num_hops=2, loop=1, guard=0, dwell=0 -> hop_idx sequence 0,1,0,1 with 2-cycle period and tx_dds_en toggling every cycle; then hop_stop -> IDLE next cycle, no done.
- Abort mid-dwell: hop_stop during DWELL of hop 1 -> tx_dds_en=0 next cycle, fcw_data unchanged; a later hop_start restarts at entry 0.
- Edge commands:
  - hop_start with num_hops=0 -> busy stays 0.
  - num_hops=20 -> 16 hops (idx 0..15) then done.
  - hop_start together with hop_stop -> no start.
- Live config: while busy, write the next entry and change cfg_dwell to 3 -> new FCW appears at the next GUARD entry; dwell stays at its latched value until the next start.
